// File: rtl/datamem_ls.sv
// Byte-addressed RV32I data memory with LB/LH/LW/LBU/LHU/SB/SH/SW support.
// A valid/ready request is answered by a one-cycle response a fixed READ_LAT edges later.
module datamem_ls #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 17,
  parameter int READ_LAT   = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [2:0]            req_funct3_i,
  input  logic [DATA_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  resp_valid_o,
  output logic [DATA_WIDTH-1:0] resp_rdata_o,
  output logic                  resp_err_o
);

  // state  | meaning
  // S_IDLE | ready for a request
  // S_WAIT | request accepted, counting down remaining latency
  // S_RESP | response strobe is on the outputs
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  localparam int DEPTH = 2 ** (ADDR_WIDTH - 2);
  localparam logic [3:0] CNT_INIT = (READ_LAT > 1) ? 4'(READ_LAT - 2) : 4'd0;

  state_t                  state_q;
  logic [3:0]              cnt_q;
  logic                    ready_q;
  logic                    resp_valid_q;
  logic [DATA_WIDTH-1:0]   resp_rdata_q;
  logic                    resp_err_q;
  logic [DATA_WIDTH-1:0]   pipe_rdata_q;
  logic                    pipe_err_q;

  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  logic [ADDR_WIDTH-3:0]   idx;
  logic [1:0]              lane;
  logic [DATA_WIDTH-1:0]   rd_word;
  logic [7:0]              byte_sel;
  logic [15:0]             half_sel;
  logic                    dec_err;
  logic [3:0]              be;
  logic [DATA_WIDTH-1:0]   wr_word;
  logic [DATA_WIDTH-1:0]   ld_ext;
  logic [DATA_WIDTH-1:0]   ld_result;
  logic                    accept;
  logic                    wr_en;
  logic                    unused_addr;

  // Upper address bits are deliberately ignored so the space wraps.
  assign unused_addr = ^req_addr_i[DATA_WIDTH-1:ADDR_WIDTH];

  assign idx      = req_addr_i[ADDR_WIDTH-1:2];
  assign lane     = req_addr_i[1:0];
  assign rd_word  = mem_q[idx];
  assign byte_sel = 8'(rd_word >> {lane, 3'b000});
  assign half_sel = lane[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    dec_err = 1'b0;
    be      = 4'b0000;
    wr_word = '0;
    ld_ext  = '0;
    case (req_funct3_i)
      3'b000: begin
        be      = 4'b0001 << lane;
        wr_word = {4{req_wdata_i[7:0]}};
        ld_ext  = {{24{byte_sel[7]}}, byte_sel};
      end
      3'b001: begin
        dec_err = lane[0];
        be      = lane[1] ? 4'b1100 : 4'b0011;
        wr_word = {2{req_wdata_i[15:0]}};
        ld_ext  = {{16{half_sel[15]}}, half_sel};
      end
      3'b010: begin
        dec_err = |lane;
        be      = 4'b1111;
        wr_word = req_wdata_i;
        ld_ext  = rd_word;
      end
      3'b100: begin
        dec_err = req_we_i;
        ld_ext  = {24'b0, byte_sel};
      end
      3'b101: begin
        dec_err = req_we_i | lane[0];
        ld_ext  = {16'b0, half_sel};
      end
      default: dec_err = 1'b1;
    endcase
  end

  assign accept    = req_valid_i && ready_q;
  assign wr_en     = accept && req_we_i && !dec_err && !rst_i;
  assign ld_result = (req_we_i || dec_err) ? '0 : ld_ext;

  // Storage has no reset so it can map onto RAM; committed stores survive rst.
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < 4; b++) begin
      if (wr_en && be[b]) begin
        mem_q[idx][8*b +: 8] <= wr_word[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      cnt_q        <= 4'd0;
      ready_q      <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      pipe_rdata_q <= '0;
      pipe_err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          resp_valid_q <= 1'b0;
          resp_rdata_q <= '0;
          resp_err_q   <= 1'b0;
          if (accept) begin
            ready_q <= 1'b0;
            if (READ_LAT == 1) begin
              state_q      <= S_RESP;
              resp_valid_q <= 1'b1;
              resp_rdata_q <= ld_result;
              resp_err_q   <= dec_err;
            end else begin
              state_q      <= S_WAIT;
              cnt_q        <= CNT_INIT;
              pipe_rdata_q <= ld_result;
              pipe_err_q   <= dec_err;
            end
          end
        end
        S_WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q      <= S_RESP;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= pipe_rdata_q;
            resp_err_q   <= pipe_err_q;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_RESP: begin
          state_q      <= S_IDLE;
          ready_q      <= 1'b1;
          resp_valid_q <= 1'b0;
          resp_rdata_q <= '0;
          resp_err_q   <= 1'b0;
        end
        default: begin
          state_q      <= S_IDLE;
          ready_q      <= 1'b1;
          resp_valid_q <= 1'b0;
          resp_rdata_q <= '0;
          resp_err_q   <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready_o  = ready_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_rdata_o = resp_rdata_q;
  assign resp_err_o   = resp_err_q;

endmodule

// File: tb/tb_datamem_ls.sv
// Self-checking bench for datamem_ls: directed cases plus randomized traffic
// against a byte-array reference model; a second instance covers READ_LAT=1.
module tb_datamem_ls;

  localparam int LAT    = 2;
  localparam int MSPACE = 131072;

  logic        clk;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;

  logic        v1, rdy1, we1, rv1, err1;
  logic [2:0]  f31;
  logic [31:0] a1, wd1, rd1;

  int tests = 0;
  int fails = 0;

  bit [7:0] ref_mem [MSPACE];

  datamem_ls #(.DATA_WIDTH(32), .ADDR_WIDTH(17), .READ_LAT(LAT)) dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_we_i(req_we), .req_funct3_i(req_funct3), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata), .resp_valid_o(resp_valid), .resp_rdata_o(resp_rdata),
    .resp_err_o(resp_err));

  datamem_ls #(.DATA_WIDTH(32), .ADDR_WIDTH(17), .READ_LAT(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(v1), .req_ready_o(rdy1),
    .req_we_i(we1), .req_funct3_i(f31), .req_addr_i(a1),
    .req_wdata_i(wd1), .resp_valid_o(rv1), .resp_rdata_o(rd1),
    .resp_err_o(err1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference behaviour: byte array, access size from funct3, little-endian.
  function automatic void model(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wd, output bit err, output logic [31:0] rd);
    int size;
    bit sgn;
    bit ok;
    int a;
    logic [31:0] v;
    ok = 1; sgn = 0; size = 4;
    case (f3)
      3'd0: begin size = 1; sgn = 1; end
      3'd1: begin size = 2; sgn = 1; end
      3'd2: size = 4;
      3'd4: begin size = 1; ok = !we; end
      3'd5: begin size = 2; ok = !we; end
      default: ok = 0;
    endcase
    err = !ok || ((addr & 32'(size - 1)) != 0);
    rd = 32'd0;
    a = int'(addr & 32'h1FFFF);
    if (!err) begin
      if (we) begin
        for (int i = 0; i < size; i++) ref_mem[(a + i) % MSPACE] = wd[8*i +: 8];
      end else begin
        v = 32'd0;
        for (int i = 0; i < size; i++) v = v | (32'(ref_mem[(a + i) % MSPACE]) << (8 * i));
        if (sgn && size < 4 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8 * size));
        rd = v;
      end
    end
  endfunction

  // Called at the first negedge after an accept; ends at the negedge where ready returns.
  task automatic check_window(input string tag, input logic [31:0] erd, input bit eerr);
    for (int k = 1; k <= LAT + 1; k++) begin
      if (k > 1) @(negedge clk);
      chk({tag, " valid"}, 32'(resp_valid), 32'(k == LAT));
      chk({tag, " rdata"}, resp_rdata, (k == LAT) ? erd : 32'd0);
      chk({tag, " err"},   32'(resp_err), 32'(k == LAT && eerr));
      chk({tag, " ready"}, 32'(req_ready), 32'(k == LAT + 1));
    end
  endtask

  task automatic do_req(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input string tag);
    bit eerr;
    logic [31:0] erd;
    int n;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " ready-wait"}, 32'(req_ready), 32'd1);
    model(we, f3, addr, wd, eerr, erd);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_wdata = $urandom;
    check_window(tag, erd, eerr);
  endtask

  // Accept one request, then pulse rst on the very next edge.
  task automatic accept_then_rst(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wd, input string tag);
    bit eerr;
    logic [31:0] erd;
    model(we, f3, addr, wd, eerr, erd);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk({tag, " rst ready"}, 32'(req_ready), 32'd1);
    for (int k = 0; k < 4; k++) begin
      chk({tag, " no resp"}, 32'(resp_valid), 32'd0);
      chk({tag, " rdata0"}, resp_rdata, 32'd0);
      @(negedge clk);
    end
  endtask

  initial begin
    bit eerr;
    logic [31:0] erd;
    bit we;
    logic [2:0] f3;
    logic [31:0] addr;

    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
    v1 = 1'b0; we1 = 1'b0; f31 = 3'd0; a1 = 32'd0; wd1 = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset ready", 32'(req_ready), 32'd1);
    chk("reset valid", 32'(resp_valid), 32'd0);
    chk("reset rdata", resp_rdata, 32'd0);
    chk("reset err", 32'(resp_err), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic word store/load and sub-word extension
    do_req(1, 3'b010, 32'h10, 32'hDEADBEEF, "SW 10");
    do_req(0, 3'b010, 32'h10, 32'h0, "LW 10");
    do_req(0, 3'b000, 32'h13, 32'h0, "LB 13");
    do_req(0, 3'b100, 32'h13, 32'h0, "LBU 13");
    do_req(0, 3'b001, 32'h12, 32'h0, "LH 12");
    do_req(0, 3'b101, 32'h12, 32'h0, "LHU 12");
    do_req(0, 3'b000, 32'h10, 32'h0, "LB 10");
    do_req(1, 3'b000, 32'h11, 32'h123456AA, "SB 11");
    do_req(0, 3'b010, 32'h10, 32'h0, "LW 10 after SB");
    do_req(1, 3'b001, 32'h12, 32'h0000BEEF, "SH 12");
    do_req(0, 3'b010, 32'h10, 32'h0, "LW 10 after SH");

    // Errors: misaligned and illegal funct3 leave memory untouched
    do_req(0, 3'b010, 32'h12, 32'h0, "LW misaligned");
    do_req(1, 3'b001, 32'h11, 32'h0000FFFF, "SH misaligned");
    do_req(0, 3'b010, 32'h10, 32'h0, "LW 10 after bad SH");
    do_req(0, 3'b011, 32'h10, 32'h0, "load f3=011");
    do_req(1, 3'b100, 32'h10, 32'hFFFFFFFF, "store f3=100");
    do_req(0, 3'b010, 32'h10, 32'h0, "LW 10 after bad store");

    // Address wrap at the top of the space
    do_req(1, 3'b010, 32'h1FFFC, 32'hA1B2C3D4, "SW top");
    do_req(0, 3'b000, 32'h1FFFF, 32'h0, "LB top byte");
    do_req(0, 3'b010, 32'h0003FFFC, 32'h0, "LW aliased top");
    do_req(0, 3'b101, 32'hFFFE0012, 32'h0, "LHU aliased 12");

    // Back-to-back: valid held for 10 cycles, accepts every LAT+1 edges
    model(0, 3'b010, 32'h10, 32'h0, eerr, erd);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10;
    for (int cyc = 0; cyc < 10; cyc++) begin
      chk($sformatf("hold ready c%0d", cyc), 32'(req_ready), 32'((cyc % 3) == 0));
      chk($sformatf("hold valid c%0d", cyc), 32'(resp_valid), 32'((cyc % 3) == 2));
      chk($sformatf("hold rdata c%0d", cyc), resp_rdata, ((cyc % 3) == 2) ? erd : 32'd0);
      @(negedge clk);
    end
    req_valid = 1'b0;
    check_window("hold tail", erd, 1'b0);

    // READ_LAT=1 instance
    v1 = 1'b1; we1 = 1'b1; f31 = 3'b010; a1 = 32'h20; wd1 = 32'hCAFEF00D;
    @(posedge clk);
    @(negedge clk);
    v1 = 1'b0;
    chk("L1 SW valid", 32'(rv1), 32'd1);
    chk("L1 SW rdata", rd1, 32'd0);
    chk("L1 SW err", 32'(err1), 32'd0);
    chk("L1 SW ready", 32'(rdy1), 32'd0);
    @(negedge clk);
    chk("L1 ready back", 32'(rdy1), 32'd1);
    chk("L1 valid drop", 32'(rv1), 32'd0);
    v1 = 1'b1; we1 = 1'b0; f31 = 3'b010; a1 = 32'h20;
    for (int cyc = 0; cyc < 10; cyc++) begin
      chk($sformatf("L1 hold ready c%0d", cyc), 32'(rdy1), 32'((cyc % 2) == 0));
      chk($sformatf("L1 hold valid c%0d", cyc), 32'(rv1), 32'((cyc % 2) == 1));
      chk($sformatf("L1 hold rdata c%0d", cyc), rd1, ((cyc % 2) == 1) ? 32'hCAFEF00D : 32'd0);
      @(negedge clk);
    end
    v1 = 1'b0;
    chk("L1 tail ready", 32'(rdy1), 32'd1);

    // Reset in flight: response dropped, committed store kept, rst beats req_valid
    do_req(1, 3'b010, 32'h40, 32'h0, "SW 40 init");
    accept_then_rst(1, 3'b010, 32'h40, 32'h0BADCAFE, "SW then rst");
    accept_then_rst(0, 3'b010, 32'h10, 32'h0, "LW then rst");
    do_req(0, 3'b010, 32'h40, 32'h0, "LW 40 after rst");
    rst = 1'b1;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h40; req_wdata = 32'h11111111;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    req_valid = 1'b0;
    chk("rst prio ready", 32'(req_ready), 32'd1);
    chk("rst prio valid", 32'(resp_valid), 32'd0);
    do_req(0, 3'b010, 32'h40, 32'h0, "LW 40 after rst prio");

    // Randomized traffic over a small window, pre-filled so every byte is known
    for (int w = 0; w < 16; w++) do_req(1, 3'b010, 32'h100 + 32'(4 * w), $urandom, "fill");
    for (int t = 0; t < 80; t++) begin
      we   = 1'($urandom_range(0, 1));
      f3   = 3'($urandom_range(0, 7));
      addr = 32'h100 + 32'($urandom_range(0, 63));
      if ($urandom_range(0, 3) == 0) addr = addr | ($urandom << 17);
      do_req(we, f3, addr, $urandom, $sformatf("rand%0d", t));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
